// File: rtl/shift_seq_ctrl_if.sv
// Purpose: bundles the request, datapath-control and result signals of shift_seq_ctrl.
// Latency: none; this file holds only wiring.
// Backpressure: out_valid/out_ready handshake on the captured word; start is only honoured when idle.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] sh_q;
    logic             out_ready;
    logic             sh_rst;
    logic             sh_en;
    logic             sh_clk_en;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             ovr;

    // requester / shift-register side
    modport master (
        output start, abort, sh_q, out_ready,
        input  sh_rst, sh_en, sh_clk_en, busy, out_valid, out_data, ovr
    );

    // controller side
    modport slave (
        input  start, abort, sh_q, out_ready,
        output sh_rst, sh_en, sh_clk_en, busy, out_valid, out_data, ovr
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Purpose: sequences one WIDTH-bit shift (clear, DIV-prescaled ticks, capture) and presents the word; optional SHSEQ_OVERRUN_EN adds a sticky overrun flag.
// Latency: start sampled at edge 0 -> out_valid from cycle 3+WIDTH*DIV; abort returns to IDLE next cycle.
// Backpressure: word held in VALID with stable out_data until out_ready; start while busy is ignored.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 2
) (
    input logic             clk,
    input logic             rst,
    shift_seq_ctrl_if.slave bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        VALID   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    pre_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic [WIDTH-1:0] data_q;

    // Shift tick depends only on state and prescaler, never on inputs.
    assign tick = (state == SHIFT) && (pre_cnt == PRE_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other input.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nxt = CLEAR;
                CLEAR:   state_nxt = SHIFT;
                SHIFT:   if (tick && (bit_cnt == BIT_LAST)) state_nxt = CAPTURE;
                CAPTURE: state_nxt = VALID;
                VALID:   if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode from state (and prescaler through tick) only.
    always_comb begin
        bus.sh_rst    = 1'b0;
        bus.sh_en     = 1'b0;
        bus.sh_clk_en = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.busy = 1'b0;
            CLEAR:   bus.sh_rst = 1'b1;
            SHIFT: begin
                bus.sh_en     = 1'b1;
                bus.sh_clk_en = tick;
            end
            CAPTURE: bus.busy = 1'b1;
            VALID:   bus.out_valid = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

    // Prescaler and bit counter only run in SHIFT; they sit at zero elsewhere, so CLEAR leaves them cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            bit_cnt <= '0;
        end else if (bus.abort || (state != SHIFT)) begin
            pre_cnt <= '0;
            bit_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Result word changes only when a CAPTURE cycle completes (an abort in that cycle keeps the old word).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if ((state == CAPTURE) && !bus.abort) begin
            data_q <= bus.sh_q;
        end
    end

    assign bus.out_data = data_q;

`ifdef SHSEQ_OVERRUN_EN
    logic ovr_q;

    // Sticky flag for a start request that arrives while a word is in flight or unaccepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if (bus.abort) begin
            ovr_q <= 1'b0;
        end else if (bus.start && ((state == CLEAR) || (state == SHIFT) || (state == CAPTURE) ||
                                   ((state == VALID) && !bus.out_ready))) begin
            ovr_q <= 1'b1;
        end
    end

    assign bus.ovr = ovr_q;
`else
    assign bus.ovr = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose: randomized scoreboard bench for shift_seq_ctrl (WIDTH=4, DIV=2 main instance, DIV=1 side instance).
// Latency: expected timing derived from the start cycle with plain arithmetic.
// Backpressure: out_ready randomized, including a forced multi-cycle hold.
module tb_shift_seq_ctrl;
    localparam int W   = 4;
    localparam int D   = 2;
    localparam int INV = -100000;
`ifdef SHSEQ_OVERRUN_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        int           vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   seq_t0 = INV;
    logic exp_ovr = 1'b0;
    logic [W-1:0] last_word = '0;
    exp_t exp_q[$];
    exp_t cur;
    logic prev_valid = 1'b0;
    int   rel;

    shift_seq_ctrl_if #(.WIDTH(W)) b ();
    shift_seq_ctrl_if #(.WIDTH(W)) b1 ();

    shift_seq_ctrl #(.WIDTH(W), .DIV(D)) dut (.clk(clk), .rst(rst), .bus(b));
    shift_seq_ctrl #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sh_rst"}, b.sh_rst, 0);
        chk({tag, "_sh_en"}, b.sh_en, 0);
        chk({tag, "_sh_clk_en"}, b.sh_clk_en, 0);
        chk({tag, "_busy"}, b.busy, 0);
        chk({tag, "_out_valid"}, b.out_valid, 0);
        chk({tag, "_out_data"}, b.out_data, 0);
        chk({tag, "_ovr"}, b.ovr, 0);
    endtask

    // One full sequence: start now, word presented on sh_q in the capture cycle,
    // out_ready held low for 'hold' VALID cycles, then random (rr) or 1.
    // xs pulses a stray start during SHIFT.
    task automatic run_seq(input logic [W-1:0] word, input int hold, input bit rr, input bit xs);
        int   t0, cap, vc, n;
        bit   acc;
        exp_t e;
        b.start = 1'b1;
        t0 = cyc;
        seq_t0 = t0;
        cap = t0 + 2 + W * D;
        vc = t0 + 3 + W * D;
        e.data = word;
        e.vcyc = vc;
        exp_q.push_back(e);
        next_cycle();
        n = 0;
        forever begin
            b.sh_q = (cyc == cap) ? word : W'($urandom);
            b.start = xs && (cyc == t0 + 5);
            if (xs && (cyc == t0 + 6)) exp_ovr = OVR_ON;
            if (cyc >= vc) begin
                if (n < hold) b.out_ready = 1'b0;
                else if (!rr || n >= hold + 8) b.out_ready = 1'b1;
                else b.out_ready = 1'($urandom_range(0, 1));
                n++;
            end else begin
                b.out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            acc = (cyc >= vc) && b.out_ready;
            next_cycle();
            if (acc) break;
        end
        b.start = 1'b0;
        last_word = word;
        chk("idle_after_accept_busy", b.busy, 0);
        chk("idle_after_accept_valid", b.out_valid, 0);
    endtask

    task automatic start_and_wait4(output int t0);
        b.start = 1'b1;
        t0 = cyc;
        seq_t0 = t0;
        next_cycle();
        b.start = 1'b0;
        while (cyc < t0 + 4) begin
            b.sh_q = W'($urandom);
            next_cycle();
        end
    endtask

    // Scoreboard monitor: per-cycle control outputs from the start-cycle arithmetic,
    // and the result word popped when out_valid rises.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_valid = 1'b0;
        end else begin
            rel = cyc - seq_t0;
            chk("sh_rst", b.sh_rst, rel == 1);
            chk("sh_en", b.sh_en, (rel >= 2) && (rel < 2 + W * D));
            chk("sh_clk_en", b.sh_clk_en, (rel >= 2) && (rel < 2 + W * D) && (((rel - 2) % D) == D - 1));
            chk("ovr", b.ovr, exp_ovr);
            if ((rel >= 1) && (rel <= 2 + W * D)) begin
                chk("busy_in_seq", b.busy, 1);
                chk("no_early_valid", b.out_valid, 0);
            end
            if (b.out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("valid_cycle", cyc, cur.vcyc);
                    chk("out_data", b.out_data, cur.data);
                end
            end else if (b.out_valid) begin
                chk("out_data_hold", b.out_data, cur.data);
            end
            prev_valid = b.out_valid;
        end
    end

    // DIV=1 instance: continuous ticks cycles 2..5, out_valid at cycle 7.
    initial begin : div1_check
        int t1;
        int r;
        b1.start = 1'b0;
        b1.abort = 1'b0;
        b1.out_ready = 1'b1;
        b1.sh_q = 4'b0110;
        wait (rst === 1'b0);
        wait (rst === 1'b1);
        repeat (3) next_cycle();
        b1.start = 1'b1;
        t1 = cyc;
        next_cycle();
        b1.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            r = cyc - t1;
            chk("d1_sh_clk_en", b1.sh_clk_en, (r >= 2) && (r <= 5));
            chk("d1_out_valid", b1.out_valid, r == 7);
            if (r == 7) chk("d1_out_data", b1.out_data, 4'b0110);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int t0;
        rst = 1'b1;
        b.start = 1'b0;
        b.abort = 1'b0;
        b.out_ready = 1'b0;
        b.sh_q = '0;
        #1 rst = 1'b0;
        #3;
        chk_all_zero("reset");
        // start already requested while in reset: taken on the first edge after release
        b.start = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        run_seq(4'b1011, 0, 1'b0, 1'b0);
        // VALID held for 5 cycles with sh_q changing underneath
        run_seq(W'($urandom), 5, 1'b1, 1'b0);
        // abort in cycle 4 (also racing a start): IDLE next cycle, word retained
        start_and_wait4(t0);
        b.abort = 1'b1;
        b.start = 1'b1;
        next_cycle();
        b.abort = 1'b0;
        b.start = 1'b0;
        seq_t0 = INV;
        chk("abort_busy", b.busy, 0);
        chk("abort_sh_en", b.sh_en, 0);
        chk("abort_out_valid", b.out_valid, 0);
        chk("abort_out_data", b.out_data, last_word);
        run_seq(W'($urandom), 0, 1'b1, 1'b0);
        // stray start in SHIFT: ignored by the sequence, flags overrun when enabled
        run_seq(W'($urandom), 0, 1'b1, 1'b1);
        repeat (3) next_cycle();
        b.abort = 1'b1;
        next_cycle();
        b.abort = 1'b0;
        exp_ovr = 1'b0;
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(0, 3)) begin
                b.sh_q = W'($urandom);
                next_cycle();
            end
            run_seq(W'($urandom), 0, 1'b1, 1'b0);
        end
        // asynchronous reset between edges in SHIFT
        start_and_wait4(t0);
        #2;
        rst = 1'b0;
        seq_t0 = INV;
        #1;
        chk_all_zero("midreset");
        exp_ovr = 1'b0;
        last_word = '0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        repeat (30) next_cycle();
        chk("pending_words", exp_q.size(), 0);
        chk("out_data_after_reset", b.out_data, last_word);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
